// File: rtl/demux_pulse_sequencer.sv
// Upstream driver for the 1-to-8 select demux: emits sel/i bursts for requested
// or round-robin scanned channels, with sel stable around every pulse of i.
module demux_pulse_sequencer #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1,
    parameter int CW        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_ch,
    output logic       req_ready,
    input  logic       scan_en,
    output logic [2:0] sel,
    output logic       i,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;
    localparam bit            HAS_GAP    = (GAP_LEN > 0);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_sel;
    logic [2:0]    r_scan_ptr;
    logic          r_i;
    logic          r_busy;
    logic          r_done;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_sel_nxt;
    logic          w_exit;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        case (r_state)
            S_IDLE: begin
                // explicit requests win over the scanner
                if (req_valid) begin
                    w_state_nxt = S_SETUP;
                    w_sel_nxt   = req_ch;
                end else if (scan_en) begin
                    w_state_nxt = S_SETUP;
                    w_sel_nxt   = r_scan_ptr;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_PULSE;
                w_cnt_nxt   = PULSE_LOAD;
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    if (HAS_GAP) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = GAP_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_exit = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

    // outputs are registered from the next state so they track r_state exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_scan_ptr <= '0;
            r_i        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_i     <= (w_state_nxt == S_PULSE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_exit;
            if (w_exit) begin
                r_scan_ptr <= r_sel + 3'd1;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE) & ~rst;
    assign sel       = r_sel;
    assign i         = r_i;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_demux_pulse_sequencer.sv
// Directed bench for demux_pulse_sequencer: default timing (4/1) on one instance,
// the PULSE_LEN=1 / GAP_LEN=0 corner on a second instance.
module tb_demux_pulse_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_req_valid, a_req_ready, a_scan_en, a_i, a_busy, a_done;
    logic [2:0] a_req_ch, a_sel;
    logic       b_rst, b_req_valid, b_req_ready, b_scan_en, b_i, b_busy, b_done;
    logic [2:0] b_req_ch, b_sel;

    int n_cmp = 0;
    int n_mis = 0;

    demux_pulse_sequencer #(.PULSE_LEN(4), .GAP_LEN(1), .CW(8)) u_dut_a (
        .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ch(a_req_ch),
        .req_ready(a_req_ready), .scan_en(a_scan_en), .sel(a_sel), .i(a_i),
        .busy(a_busy), .done(a_done)
    );

    demux_pulse_sequencer #(.PULSE_LEN(1), .GAP_LEN(0), .CW(8)) u_dut_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ch(b_req_ch),
        .req_ready(b_req_ready), .scan_en(b_scan_en), .sel(b_sel), .i(b_i),
        .busy(b_busy), .done(b_done)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int done_cnt;

    initial begin
        a_rst = 1'b1; a_req_valid = 1'b0; a_req_ch = 3'd0; a_scan_en = 1'b0;
        b_rst = 1'b1; b_req_valid = 1'b0; b_req_ch = 3'd0; b_scan_en = 1'b0;
        step(); step();
        check_val("rst_sel", a_sel, 0);
        check_val("rst_i", a_i, 0);
        check_val("rst_busy", a_busy, 0);
        check_val("rst_done", a_done, 0);
        check_val("rst_ready", a_req_ready, 0);
        a_rst = 1'b0; b_rst = 1'b0;
        #1;
        check_val("idle_ready", a_req_ready, 1);

        // single request ch=5 accepted at edge 0; cycle k is the period after edge k-1
        a_req_valid = 1'b1; a_req_ch = 3'd5;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                a_req_valid = 1'b0;
                a_req_ch    = 3'd1;
            end
            check_val($sformatf("t1_sel_c%0d", k), a_sel, 5);
            check_val($sformatf("t1_i_c%0d", k), a_i, (k >= 2 && k <= 5) ? 1 : 0);
            check_val($sformatf("t1_busy_c%0d", k), a_busy, (k >= 1 && k <= 6) ? 1 : 0);
            check_val($sformatf("t1_done_c%0d", k), a_done, (k == 7) ? 1 : 0);
            check_val($sformatf("t1_ready_c%0d", k), a_req_ready, (k >= 7) ? 1 : 0);
        end

        // back-to-back: ch=3, then ch=6 held valid through the first burst
        a_req_valid = 1'b1; a_req_ch = 3'd3;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) a_req_ch = 3'd6;
            if (k == 8) a_req_valid = 1'b0;
            if (k == 6) begin
                check_val("t2_gap_sel", a_sel, 3);
                check_val("t2_gap_i", a_i, 0);
            end
            if (k == 7) begin
                check_val("t2_done1", a_done, 1);
                check_val("t2_done1_sel", a_sel, 3);
                check_val("t2_done1_ready", a_req_ready, 1);
            end
            if (k == 8) begin
                check_val("t2_setup2_sel", a_sel, 6);
                check_val("t2_setup2_i", a_i, 0);
                check_val("t2_setup2_busy", a_busy, 1);
                check_val("t2_setup2_done", a_done, 0);
            end
            if (k == 9) begin
                check_val("t2_pulse2_i", a_i, 1);
                check_val("t2_pulse2_sel", a_sel, 6);
            end
            if (k == 14) begin
                check_val("t2_done2", a_done, 1);
                check_val("t2_done2_sel", a_sel, 6);
            end
        end

        // request ch=5 leaves scan_ptr at 6
        a_req_valid = 1'b1; a_req_ch = 3'd5;
        step();
        a_req_valid = 1'b0;
        for (int k = 2; k <= 7; k++) step();
        check_val("t3_pre_done", a_done, 1);

        // request ch=2 vs scan (ptr 6): request wins, scan then resumes at 3
        a_scan_en = 1'b1; a_req_valid = 1'b1; a_req_ch = 3'd2;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 1) begin
                a_req_valid = 1'b0;
                check_val("t3_req_sel", a_sel, 2);
            end
            if (k == 7) check_val("t3_req_done", a_done, 1);
            if (k == 8) begin
                check_val("t3_scan_sel", a_sel, 3);
                check_val("t3_scan_busy", a_busy, 1);
                a_scan_en = 1'b0;
            end
            if (k == 14) begin
                check_val("t3_scan_done", a_done, 1);
                check_val("t3_scan_done_sel", a_sel, 3);
            end
            if (k == 15) check_val("t3_no_new_scan", a_busy, 0);
        end

        // scan from reset: channels 0..7,0, one done per burst
        a_rst = 1'b1; a_scan_en = 1'b1;
        step(); step();
        a_rst = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 63; c++) begin
            step();
            if (c % 7 == 1) check_val($sformatf("t4_scan_sel_c%0d", c), a_sel, ((c - 1) / 7) % 8);
            if (c % 7 == 3) check_val($sformatf("t4_scan_i_c%0d", c), a_i, 1);
            if (a_done) done_cnt++;
            if (c == 63) a_scan_en = 1'b0;
        end
        check_val("t4_done_count", done_cnt, 9);

        // reset mid-pulse on ch=4
        a_req_valid = 1'b1; a_req_ch = 3'd4;
        step();
        a_req_valid = 1'b0;
        step(); step();
        check_val("t5_pulse_i", a_i, 1);
        check_val("t5_pulse_sel", a_sel, 4);
        #2 a_rst = 1'b1;
        #1;
        check_val("t5_async_i", a_i, 0);
        check_val("t5_async_sel", a_sel, 0);
        check_val("t5_async_busy", a_busy, 0);
        check_val("t5_async_ready", a_req_ready, 0);
        a_scan_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val($sformatf("t5_rst_done_%0d", k), a_done, 0);
        end
        a_rst = 1'b0;
        step();
        check_val("t5_after_sel", a_sel, 0);
        check_val("t5_after_busy", a_busy, 1);
        check_val("t5_after_done", a_done, 0);

        // PULSE_LEN=1, GAP_LEN=0, request ch=7
        b_req_valid = 1'b1; b_req_ch = 3'd7;
        step();
        b_req_valid = 1'b0;
        check_val("t6_setup_sel", b_sel, 7);
        check_val("t6_setup_i", b_i, 0);
        check_val("t6_setup_busy", b_busy, 1);
        step();
        check_val("t6_pulse_i", b_i, 1);
        check_val("t6_pulse_sel", b_sel, 7);
        step();
        check_val("t6_done", b_done, 1);
        check_val("t6_done_i", b_i, 0);
        check_val("t6_done_busy", b_busy, 0);
        check_val("t6_done_ready", b_req_ready, 1);
        step();
        check_val("t6_done_once", b_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        n_mis++;
        $display("FAIL timeout: simulation did not complete within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "timeout");
    end

endmodule
